controle_elevador: RTL and testbench
====================================

// Module: controle_elevador
// PURPOSE
//  Sequences the 4-floor elevator car: latches floor calls, moves the car one floor at a time,
//  and holds the door open at served floors. Calls are scheduled SCAN-style.
//  Sits between the call-button inputs and the floor 7-segment decoder; andar drives that decoder.
// PARAMETERS
//  T_ANDAR  8  clock cycles to travel between adjacent floors (>=2)
//  T_PORTA  16 clock cycles the door stays open (>=2)
//  W_CONT   5  timer width; must hold max(T_ANDAR,T_PORTA)-1
// PORTS
//  clk           in   1  single system clock, rising edge
//  reset         in   1  asynchronous, active-high reset
//  chamada       in   4  call buttons; bit k is a request for floor k, sampled every cycle (level or pulse)
//  andar         out  2  current floor, 0..3
//  subindo       out  1  car moving up
//  descendo      out  1  car moving down
//  porta_aberta  out  1  door open
//  pendentes     out  4  latched, not yet served calls
// BEHAVIOUR
//  Reset: andar=0, pendentes=0, porta_aberta=0, subindo=0, descendo=0, state PARADO,
//   timer=0, dir=UP. Reset mid-travel or mid-door-open abandons the operation immediately.
//  Latching: pendentes[k] <= pendentes[k] | chamada[k] every cycle, except the clear rules below.
//  States: PARADO, SUBINDO, DESCENDO, PORTA (one-hot or binary; outputs decoded from state only).
//  PARADO (car stopped at floor f, door closed), one decision per cycle, using pendentes|chamada:
//   - bit f set      -> PORTA; clear bit f; timer=0
//   - else if any set above f and any set below f -> move in dir (last direction)
//   - else if any above -> SUBINDO, dir=UP; any below -> DESCENDO, dir=DOWN; timer=0
//   - else stay in PARADO
//  SUBINDO/DESCENDO: timer counts 0..T_ANDAR-1. At the edge where timer==T_ANDAR-1:
//   andar +/-1 (new floor g). Same edge, decided with pendentes|chamada:
//   - bit g set -> PORTA, clear bit g, timer=0
//   - else a call beyond g in the same direction -> keep moving, timer=0
//   - else -> PARADO
//  PORTA: timer counts 0..T_PORTA-1; at T_PORTA-1 -> PARADO.
//   chamada[andar] while in PORTA restarts timer to 0; the bit stays clear (call is served).
//  Clear-vs-set on the same cycle for the served floor: clear wins (call is absorbed).
//   Calls for any other floor are never lost.
//  Calls for the current floor while moving are not served until the car returns to that floor.
//  andar never leaves 0..3: motion is entered only when a call exists beyond the current floor.
//  Outputs are registered or decoded from state only; none is combinational from chamada.
//  Latency: call at the idle car's floor -> porta_aberta=1 on the next edge.
//   Call 1 floor away -> andar changes T_ANDAR+1 edges after the call is sampled.
// STRUCTURE
//  Include file elevador_defs.vh: state encodings (PARADO/SUBINDO/DESCENDO/PORTA),
//   DIR_UP/DIR_DOWN, N_ANDARES=4. Shared with the decoder/testbench.
//  Sub-module temporizador_elevador: W_CONT-bit counter with sync clear, enable,
//   and a "fim" compare input.
//   Instantiated once; compare value muxed between T_ANDAR-1 and T_PORTA-1 by state.
//  "Above/below" masks: combinational functions of andar and pendentes|chamada, in this module.
// TESTING (T_ANDAR=4, T_PORTA=6)
//  1 Reset while moving between floors 1->2 -> next cycle andar=0, pendentes=0,
//    all status outputs 0; no motion afterwards.
//  2 Idle at 0, 1-cycle pulse chamada=4'b0001 -> porta_aberta=1 next edge,
//    held 6 cycles, then PARADO; pendentes stays 0.
//  3 Idle at 0, pulse chamada=4'b1000 -> subindo=1; andar 1,2,3 every 4 cycles;
//    door opens at 3; no stop at 1 or 2.
//  4 Car at 1 going up to 3; chamada=4'b0101 during travel ->
//    serves 2 (door), then 3, then reverses, then 0.
//    Floor 1 not served on the way up.
//  5 Door open at 2, chamada[2] held 10 cycles -> door stays open 10+6 cycles;
//    pendentes[2]=0 throughout.
//  6 Idle at 1, dir=UP, chamada=4'b1001 same cycle -> goes up to 3 first, then down to 0;
//    both bits cleared exactly on service.

Source files
------------

// File: rtl/controle_elevador_pkg.sv
// Shared definitions for the elevator controller: FSM states, travel
// direction and number of floors served by the car.
package controle_elevador_pkg;

  localparam int N_ANDARES = 4;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    SUBINDO  = 2'd1,
    DESCENDO = 2'd2,
    PORTA    = 2'd3
  } estado_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/controle_elevador_temporizador.sv
// Shared travel/door timer: counts up while enabled, clears synchronously,
// and flags when the count matches the compare value chosen by the FSM.
module temporizador_elevador #(
  parameter int W_CONT = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [W_CONT-1:0] limite,
  output logic              fim
);

  logic [W_CONT-1:0] contagem;

  // Counter register: clear has priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    contagem <= '0;
    else if (clr) contagem <= '0;
    else if (en)  contagem <= contagem + 1'b1;
  end

  assign fim = (contagem == limite);

endmodule

// File: rtl/controle_elevador.sv
// 4-floor elevator car sequencer with SCAN scheduling: latches calls,
// moves one floor per T_ANDAR cycles and holds the door for T_PORTA cycles.
module controle_elevador
  import controle_elevador_pkg::*;
#(
  parameter int T_ANDAR = 8,
  parameter int T_PORTA = 16,
  parameter int W_CONT  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] chamada,
  output logic [1:0] andar,
  output logic       subindo,
  output logic       descendo,
  output logic       porta_aberta,
  output logic [3:0] pendentes
);

  localparam logic [W_CONT-1:0] LIM_ANDAR = W_CONT'(T_ANDAR - 1);
  localparam logic [W_CONT-1:0] LIM_PORTA = W_CONT'(T_PORTA - 1);

  estado_t    estado, proxEstado;
  dir_t       dir, proxDir;
  logic [1:0] proxAndar, andarSeg;
  logic [3:0] req, proxPend;
  logic       tmrClr, tmrEn, tmrFim;
  logic [W_CONT-1:0] tmrLimite;

  // True when any requested floor lies strictly above f.
  function automatic logic haAcima(input logic [1:0] f, input logic [3:0] r);
    logic a;
    a = 1'b0;
    for (int k = 0; k < N_ANDARES; k++)
      if (k > int'(f) && r[k]) a = 1'b1;
    return a;
  endfunction

  // True when any requested floor lies strictly below f.
  function automatic logic haAbaixo(input logic [1:0] f, input logic [3:0] r);
    logic b;
    b = 1'b0;
    for (int k = 0; k < N_ANDARES; k++)
      if (k < int'(f) && r[k]) b = 1'b1;
    return b;
  endfunction

  // Decisions see calls arriving this cycle as well as latched ones.
  assign req       = pendentes | chamada;
  assign andarSeg  = (estado == DESCENDO) ? andar - 2'd1 : andar + 2'd1;
  assign tmrLimite = (estado == PORTA) ? LIM_PORTA : LIM_ANDAR;

  temporizador_elevador #(.W_CONT(W_CONT)) uTemporizador (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmrClr),
    .en     (tmrEn),
    .limite (tmrLimite),
    .fim    (tmrFim)
  );

  // Next-state, floor, direction, call latch and timer control.
  always_comb begin
    proxEstado = estado;
    proxAndar  = andar;
    proxDir    = dir;
    proxPend   = req;
    tmrClr     = 1'b0;
    tmrEn      = 1'b0;
    case (estado)
      PARADO: begin
        tmrClr = 1'b1;
        if (req[andar]) begin
          proxEstado      = PORTA;
          proxPend[andar] = 1'b0;
        end else if (haAcima(andar, req) && haAbaixo(andar, req)) begin
          proxEstado = (dir == DIR_UP) ? SUBINDO : DESCENDO;
        end else if (haAcima(andar, req)) begin
          proxEstado = SUBINDO;
          proxDir    = DIR_UP;
        end else if (haAbaixo(andar, req)) begin
          proxEstado = DESCENDO;
          proxDir    = DIR_DOWN;
        end
      end
      SUBINDO, DESCENDO: begin
        if (tmrFim) begin
          // Arrival edge: the car reaches andarSeg and decides what to do there.
          tmrClr    = 1'b1;
          proxAndar = andarSeg;
          if (req[andarSeg]) begin
            proxEstado         = PORTA;
            proxPend[andarSeg] = 1'b0;
          end else if ((estado == SUBINDO)  && haAcima(andarSeg, req)) begin
            proxEstado = SUBINDO;
          end else if ((estado == DESCENDO) && haAbaixo(andarSeg, req)) begin
            proxEstado = DESCENDO;
          end else begin
            proxEstado = PARADO;
          end
        end else begin
          tmrEn = 1'b1;
        end
      end
      PORTA: begin
        // A call for this floor while the door is open is absorbed and
        // keeps the door open for a fresh full period.
        proxPend[andar] = 1'b0;
        if (chamada[andar]) begin
          tmrClr = 1'b1;
        end else if (tmrFim) begin
          tmrClr     = 1'b1;
          proxEstado = PARADO;
        end else begin
          tmrEn = 1'b1;
        end
      end
      default: begin
        proxEstado = PARADO;
        tmrClr     = 1'b1;
      end
    endcase
  end

  // Controller state registers; reset abandons any travel or door period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado    <= PARADO;
      andar     <= 2'd0;
      dir       <= DIR_UP;
      pendentes <= 4'b0000;
    end else begin
      estado    <= proxEstado;
      andar     <= proxAndar;
      dir       <= proxDir;
      pendentes <= proxPend;
    end
  end

  assign subindo      = (estado == SUBINDO);
  assign descendo     = (estado == DESCENDO);
  assign porta_aberta = (estado == PORTA);

endmodule

// File: tb/tb_controle_elevador.sv
// Self-checking bench for controle_elevador: directed scenarios followed by
// random calls, all compared every cycle against a behavioural car model.
module tb_controle_elevador;

  localparam int T_ANDAR = 4;
  localparam int T_PORTA = 6;
  localparam int W_CONT  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] chamada = 4'b0000;
  logic [1:0] andar;
  logic       subindo, descendo, porta_aberta;
  logic [3:0] pendentes;

  int checks = 0;
  int errors = 0;

  // Behavioural model: floor number, signed motion (+1/-1/0), door flag,
  // cycles remaining before the next floor arrival / door close.
  int         mFloor, mMove, mLastDir, mLeft;
  bit         mDoor;
  logic [3:0] mPend;

  controle_elevador #(.T_ANDAR(T_ANDAR), .T_PORTA(T_PORTA), .W_CONT(W_CONT)) dut (
    .clk          (clk),
    .reset        (reset),
    .chamada      (chamada),
    .andar        (andar),
    .subindo      (subindo),
    .descendo     (descendo),
    .porta_aberta (porta_aberta),
    .pendentes    (pendentes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit callBeyond(input int f, input int d, input logic [3:0] r);
    bit any;
    any = 0;
    for (int k = 0; k < 4; k++)
      if (r[k] && ((d > 0 && k > f) || (d < 0 && k < f))) any = 1;
    return any;
  endfunction

  task automatic modelReset();
    mFloor = 0; mMove = 0; mLastDir = 1; mLeft = 0; mDoor = 0; mPend = 4'b0000;
  endtask

  task automatic openDoor(inout logic [3:0] r);
    r[mFloor] = 1'b0;
    mDoor = 1;
    mMove = 0;
    mLeft = T_PORTA - 1;
  endtask

  task automatic modelStep(input logic [3:0] c);
    logic [3:0] r;
    bit up, dn;
    r = mPend | c;
    if (mDoor) begin
      r[mFloor] = 1'b0;
      if (c[mFloor])      mLeft = T_PORTA - 1;
      else if (mLeft == 0) mDoor = 0;
      else                mLeft--;
    end else if (mMove != 0) begin
      if (mLeft == 0) begin
        mFloor += mMove;
        if (r[mFloor])                         openDoor(r);
        else if (callBeyond(mFloor, mMove, r)) mLeft = T_ANDAR - 1;
        else                                   mMove = 0;
      end else begin
        mLeft--;
      end
    end else begin
      if (r[mFloor]) begin
        openDoor(r);
      end else begin
        up = callBeyond(mFloor, 1, r);
        dn = callBeyond(mFloor, -1, r);
        if (up && dn) mMove = mLastDir;
        else if (up)  mMove = 1;
        else if (dn)  mMove = -1;
        if (mMove != 0) begin
          mLastDir = mMove;
          mLeft = T_ANDAR - 1;
        end
      end
    end
    mPend = r;
  endtask

  task automatic compareAll(input string tag);
    chk({tag, ".andar"},     8'(andar),        8'(mFloor));
    chk({tag, ".subindo"},   8'(subindo),      8'(mMove == 1));
    chk({tag, ".descendo"},  8'(descendo),     8'(mMove == -1));
    chk({tag, ".porta"},     8'(porta_aberta), 8'(mDoor));
    chk({tag, ".pendentes"}, 8'(pendentes),    8'(mPend));
  endtask

  // One clock: drive calls away from the edge, advance model, sample after edge.
  task automatic step(input logic [3:0] c, input string tag);
    @(negedge clk);
    chamada = c;
    @(posedge clk);
    modelStep(c);
    #1;
    compareAll(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(4'b0000, tag);
  endtask

  // Asynchronous reset asserted between edges, released after one edge.
  task automatic doReset(input string tag);
    @(negedge clk);
    chamada = 4'b0000;
    reset = 1'b1;
    #1;
    modelReset();
    compareAll(tag);
    @(posedge clk);
    #1;
    compareAll(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    modelReset();
    doReset("rst0");

    // Scenario 1: reset while travelling between floors 1 and 2.
    step(4'b0100, "s1call");
    idle(5, "s1move");
    chk("s1.midtravel.andar", 8'(andar), 8'd1);
    chk("s1.midtravel.subindo", 8'(subindo), 8'd1);
    doReset("s1rst");
    idle(20, "s1after");
    chk("s1.stay.andar", 8'(andar), 8'd0);

    // Scenario 2: call at current floor opens the door next edge for 6 cycles.
    step(4'b0001, "s2call");
    chk("s2.doornext", 8'(porta_aberta), 8'd1);
    idle(5, "s2door");
    chk("s2.stillopen", 8'(porta_aberta), 8'd1);
    step(4'b0000, "s2close");
    chk("s2.closed", 8'(porta_aberta), 8'd0);
    chk("s2.pend", 8'(pendentes), 8'd0);

    // Scenario 3: call for floor 3 from floor 0, no intermediate stops.
    step(4'b1000, "s3call");
    idle(11, "s3move");
    chk("s3.before.andar", 8'(andar), 8'd2);
    step(4'b0000, "s3arrive");
    chk("s3.arrive.andar", 8'(andar), 8'd3);
    chk("s3.arrive.porta", 8'(porta_aberta), 8'd1);
    idle(10, "s3rest");

    // Scenario 4: going up 1->3, calls for 0 and 2 arrive en route.
    doReset("s4rst");
    step(4'b1000, "s4call");
    idle(5, "s4move");
    step(4'b0101, "s4extra");
    idle(60, "s4run");
    chk("s4.end.andar", 8'(andar), 8'd0);

    // Scenario 5: door at 2 held open by a 10-cycle call at that floor.
    doReset("s5rst");
    step(4'b0100, "s5call");
    idle(8, "s5move");
    chk("s5.atdoor", 8'(porta_aberta), 8'd1);
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, "s5hold");
      chk("s5.hold.pend2", 8'(pendentes[2]), 8'd0);
      chk("s5.hold.porta", 8'(porta_aberta), 8'd1);
    end
    idle(5, "s5tail");
    chk("s5.tail.porta", 8'(porta_aberta), 8'd1);
    step(4'b0000, "s5close");
    chk("s5.closed", 8'(porta_aberta), 8'd0);

    // Scenario 6: idle at 1 with last direction up, calls for 0 and 3 together.
    doReset("s6rst");
    step(4'b0010, "s6go1");
    idle(12, "s6settle");
    step(4'b1001, "s6call");
    chk("s6.goesup", 8'(subindo), 8'd1);
    idle(60, "s6run");
    chk("s6.end.andar", 8'(andar), 8'd0);
    chk("s6.end.pend", 8'(pendentes), 8'd0);

    // Random traffic with occasional held buttons and resets.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 699) == 0) doReset("rndrst");
      else step(c, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
